sa_a_skew_feeder: RTL and testbench



---
 rtl/sa_a_skew_feeder_pkg.sv | 18 +
 rtl/sa_a_skew_feeder_if.sv | 39 +++
 rtl/sa_a_skew_feeder_delay_line.sv | 36 +++
 rtl/sa_a_skew_feeder.sv | 144 ++++++++++++++
 tb/tb_sa_a_skew_feeder.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/sa_a_skew_feeder_pkg.sv
// Shared types for the systolic-array operand feeders: element type, default widths
// and the tile-sequencer state encoding.
package sa_pkg;

    localparam int ELEM_BITS_DEF = 8;
    localparam int ACC_BITS_DEF  = 32;

    typedef logic signed [7:0] elem_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        FEED  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } feeder_state_e;

endpackage

// File: rtl/sa_a_skew_feeder_if.sv
// Bus bundle between the tile controller/upstream source (master) and the west-edge
// skew feeder (slave). stall_cnt exists only when SA_FEEDER_STALL_CNT_EN is defined.
interface sa_a_skew_feeder_if #(
    parameter int N         = 4,
    parameter int ELEM_BITS = 8,
    parameter int K_BITS    = 16
);
    logic                   start;
    logic [K_BITS-1:0]      k_len;
    logic                   s_valid;
    logic                   s_ready;
    logic [N*ELEM_BITS-1:0] s_data;
    logic [N*ELEM_BITS-1:0] row_data;
    logic [N-1:0]           row_valid;
    logic                   shift_en;
    logic                   clr;
    logic                   busy;
    logic                   done;
`ifdef SA_FEEDER_STALL_CNT_EN
    logic [31:0]            stall_cnt;
`endif

    modport master (
`ifdef SA_FEEDER_STALL_CNT_EN
        input  stall_cnt,
`endif
        output start, k_len, s_valid, s_data,
        input  s_ready, row_data, row_valid, shift_en, clr, busy, done
    );

    modport slave (
`ifdef SA_FEEDER_STALL_CNT_EN
        output stall_cnt,
`endif
        input  start, k_len, s_valid, s_data,
        output s_ready, row_data, row_valid, shift_en, clr, busy, done
    );

endinterface

// File: rtl/sa_a_skew_feeder_delay_line.sv
// Fixed-depth {data, valid} shift register; advances only while i_en is high.
module sa_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_en,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout
);

    logic [W-1:0] r_stage [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [W-1:0] w_src;
            if (gi == 0) begin : g_head
                assign w_src = i_din;
            end else begin : g_tail
                assign w_src = r_stage[gi-1];
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_stage[gi] <= '0;
                end else if (i_en) begin
                    r_stage[gi] <= w_src;
                end
            end
        end
    endgenerate

    assign o_dout = r_stage[DEPTH-1];

endmodule

// File: rtl/sa_a_skew_feeder.sv
// West-edge operand feeder: sequences clear/feed/flush/done per tile and skews row i
// by i cycles. Optional stall counter enabled by SA_FEEDER_STALL_CNT_EN.
module sa_a_skew_feeder
    import sa_pkg::*;
#(
    parameter int N         = 4,
    parameter int ELEM_BITS = ELEM_BITS_DEF,
    parameter int K_BITS    = 16
) (
    input  logic               clk,
    input  logic               rstn,
    sa_a_skew_feeder_if.slave  bus
);

    localparam int FL_W = (N > 1) ? $clog2(N) : 1;

    feeder_state_e          r_state;
    logic [K_BITS-1:0]      r_k_len;
    logic [K_BITS-1:0]      r_cnt;
    logic [FL_W-1:0]        r_flush_cnt;
    logic                   r_s_ready;
    logic                   r_busy;
    logic                   r_clr;
    logic                   r_done;
    logic                   w_hs;
    logic [N*ELEM_BITS-1:0] w_row_data;
    logic [N-1:0]           w_row_valid;

    assign w_hs = bus.s_valid & r_s_ready;

    // Outputs are decoded from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_k_len     <= '0;
            r_cnt       <= '0;
            r_flush_cnt <= '0;
            r_s_ready   <= 1'b0;
            r_busy      <= 1'b0;
            r_clr       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.k_len != '0) begin
                            r_k_len <= bus.k_len;
                            r_state <= CLR;
                            r_clr   <= 1'b1;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                CLR: begin
                    r_state   <= FEED;
                    r_clr     <= 1'b0;
                    r_s_ready <= 1'b1;
                    r_cnt     <= '0;
                end
                FEED: begin
                    if (w_hs) begin
                        r_cnt <= r_cnt + K_BITS'(1);
                        if (r_cnt == r_k_len - K_BITS'(1)) begin
                            r_state     <= FLUSH;
                            r_s_ready   <= 1'b0;
                            r_flush_cnt <= '0;
                        end
                    end
                end
                FLUSH: begin
                    r_flush_cnt <= r_flush_cnt + FL_W'(1);
                    if (r_flush_cnt == FL_W'(N-1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // One delay line per row; a non-handshake busy cycle inserts a bubble in every row
    // so the diagonal stays aligned across input stalls.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_row
            elem_t                w_elem;
            logic [ELEM_BITS:0]   w_entry;
            logic [ELEM_BITS:0]   w_out;

            assign w_elem  = elem_t'(bus.s_data[gi*ELEM_BITS +: ELEM_BITS]);
            assign w_entry = w_hs ? {ELEM_BITS'(w_elem), 1'b1} : '0;

            sa_delay_line #(
                .DEPTH (gi + 1),
                .W     (ELEM_BITS + 1)
            ) u_dl (
                .clk    (clk),
                .rstn   (rstn),
                .i_en   (r_busy),
                .i_din  (w_entry),
                .o_dout (w_out)
            );

            assign w_row_data[gi*ELEM_BITS +: ELEM_BITS] = w_out[ELEM_BITS:1];
            assign w_row_valid[gi]                       = w_out[0];
        end
    endgenerate

`ifdef SA_FEEDER_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
        end else if (r_state == CLR) begin
            r_stall_cnt <= '0;
        end else if ((r_state == FEED) && !bus.s_valid && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

    assign bus.s_ready   = r_s_ready;
    assign bus.busy      = r_busy;
    // The delay lines advance exactly when busy, so the array forward enable is busy.
    assign bus.shift_en  = r_busy;
    assign bus.clr       = r_clr;
    assign bus.done      = r_done;
    assign bus.row_data  = w_row_data;
    assign bus.row_valid = w_row_valid;

endmodule

// File: tb/tb_sa_a_skew_feeder.sv
// Directed + randomized bench for sa_a_skew_feeder; reference keeps a history of the
// slices presented on each busy cycle and expects row i to show slice (i+1 cycles ago).
`timescale 1ns/1ps
module tb_sa_a_skew_feeder;

    localparam int N  = 4;
    localparam int EB = 8;
    localparam int KB = 16;

    typedef struct packed {
        logic [N*EB-1:0] d;
        logic            v;
    } slice_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sa_a_skew_feeder_if #(.N(N), .ELEM_BITS(EB), .K_BITS(KB)) bus ();

    sa_a_skew_feeder #(.N(N), .ELEM_BITS(EB), .K_BITS(KB)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    slice_t          hist[$];
    int              vectors     = 0;
    int              miscompares = 0;
    logic            e_busy, e_clr, e_done, e_ready;
    logic [31:0]     e_stall;
    logic [N*EB-1:0] dtab [16];
    int              stall_at, stall_len;
    bit              rnd_valid, inject_start, abort_flush;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check this cycle's outputs, advance the reference, move to the next cycle.
    task automatic cycle();
        logic [N*EB-1:0] ed;
        logic [N-1:0]    ev;
        slice_t          s;
        @(negedge clk);
        ed = '0;
        ev = '0;
        for (int i = 0; i < N; i++) begin
            if (i < hist.size() && hist[i].v) begin
                ed[i*EB +: EB] = hist[i].d[i*EB +: EB];
                ev[i]          = 1'b1;
            end
        end
        chk("row_data",  bus.row_data,  ed);
        chk("row_valid", bus.row_valid, ev);
        chk("busy",      bus.busy,      e_busy);
        chk("shift_en",  bus.shift_en,  e_busy);
        chk("clr",       bus.clr,       e_clr);
        chk("done",      bus.done,      e_done);
        chk("s_ready",   bus.s_ready,   e_ready);
`ifdef SA_FEEDER_STALL_CNT_EN
        chk("stall_cnt", bus.stall_cnt, e_stall);
`endif
        if (e_busy) begin
            s.v = e_ready && bus.s_valid;
            s.d = bus.s_data;
            hist.push_front(s);
            if (hist.size() > N) void'(hist.pop_back());
        end
        if (e_ready && !bus.s_valid) e_stall = e_stall + 32'd1;
        if (e_clr) e_stall = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_busy",      bus.busy,      1'b0);
        chk("rst_row_valid", bus.row_valid, '0);
        chk("rst_row_data",  bus.row_data,  '0);
        chk("rst_done",      bus.done,      1'b0);
        hist.delete();
        e_busy = 0; e_clr = 0; e_done = 0; e_ready = 0; e_stall = '0;
        cycle();
        rstn = 1'b1;
        cycle();
        cycle();
    endtask

    task automatic run_tile(input int k);
        int beats, gap, stalls;
        bus.start   = 1'b1;
        bus.k_len   = KB'(k);
        bus.s_valid = 1'b0;
        cycle();
        bus.start = 1'b0;
        bus.k_len = KB'($urandom);
        if (k == 0) begin
            e_done = 1; cycle(); e_done = 0;
            return;
        end
        e_clr = 1; e_busy = 1; cycle();
        e_clr = 0; e_ready = 1;
        beats = 0; gap = 0; stalls = 0;
        while (beats < k) begin
            bus.start = inject_start && (beats == 1);
            bus.k_len = KB'($urandom_range(1, 40));
            if (beats == stall_at && stalls < stall_len) begin
                bus.s_valid = 1'b0; stalls++;
            end else if (rnd_valid && gap < 3 && $urandom_range(0, 2) == 0) begin
                bus.s_valid = 1'b0; gap++;
            end else begin
                bus.s_valid = 1'b1; gap = 0;
            end
            bus.s_data = (bus.s_valid && beats < 16) ? dtab[beats] : (N*EB)'($urandom);
            cycle();
            if (bus.s_valid) beats++;
        end
        bus.start = 1'b0; bus.s_valid = 1'b0; bus.s_data = (N*EB)'($urandom);
        e_ready = 0;
        for (int f = 0; f < N; f++) begin
            if (abort_flush && f == 2) begin
                do_reset();
                return;
            end
            cycle();
        end
        e_busy = 0; e_done = 1; cycle(); e_done = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.k_len = '0; bus.s_valid = 1'b0; bus.s_data = '0;
        e_busy = 0; e_clr = 0; e_done = 0; e_ready = 0; e_stall = '0;
        stall_at = -1; stall_len = 0; rnd_valid = 0; inject_start = 0; abort_flush = 0;
        for (int i = 0; i < 16; i++) dtab[i] = (N*EB)'($urandom);
        @(posedge clk); #1;
        cycle();
        rstn = 1'b1;
        cycle();

        // Basic tile
        dtab[0] = 32'h04030201; dtab[1] = 32'h08070605; dtab[2] = 32'h0c0b0a09;
        run_tile(3);

        // Two-cycle stall between beats 1 and 2
        stall_at = 1; stall_len = 2;
        run_tile(3);
`ifdef SA_FEEDER_STALL_CNT_EN
        chk("stall_total", bus.stall_cnt, 32'd2);
`endif
        stall_at = -1; stall_len = 0;

        // Zero-length tile, then a start ignored during FEED
        run_tile(0);
        inject_start = 1;
        run_tile(5);
        inject_start = 0;

        // Reset in FLUSH, then a fresh single-beat signed tile
        abort_flush = 1;
        run_tile(4);
        abort_flush = 0;
        dtab[0] = 32'hFFFEFD80;
        run_tile(1);

        // Back-to-back tiles with random stalls and data
        rnd_valid = 1;
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 16; i++) dtab[i] = (N*EB)'($urandom);
            inject_start = ($urandom_range(0, 1) == 1);
            run_tile($urandom_range(1, 20));
        end
        inject_start = 0;
        run_tile(0);
        run_tile(2);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
